// File: rtl/rv_pkg.sv
// rv_pkg: shared opcodes, instruction classes, error codes and loader states for the RV64I encoder.
package rv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic [2:0] {
    CLS_R, CLS_I_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_LUI, CLS_JAL, CLS_RSVD
  } instr_class_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_BAD_CLASS, ERR_IMM_RANGE, ERR_OVERFLOW} err_code_e;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_e;
endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational mapping of class plus fields to a 32-bit RV64I word.
// Immediate range checking is compiled in with ENCODER_RANGE_CHECK_EN.
module instr_field_packer
  import rv_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        bad_class,
  output logic        imm_bad
);
  logic shift;
  assign shift = func3[1:0] == 2'b01;
`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [31:0] s;
  logic i12;
  assign s = imm;
  assign i12 = s >= -2048 && s <= 2047;
`endif
  always_comb begin
    word = '0;
    bad_class = 1'b0;
    imm_bad = 1'b0;
    case (instr_class_e'(cls))
      CLS_R:      word = {func7, rs2, rs1, func3, rd, OP_R};
      CLS_I_ALU:  word = shift ? {func7[6:1], imm[5:0], rs1, func3, rd, OP_IMM}
                               : {imm[11:0], rs1, func3, rd, OP_IMM};
      CLS_LOAD:   word = {imm[11:0], rs1, func3, rd, OP_LOAD};
      CLS_STORE:  word = {imm[11:5], rs2, rs1, func3, imm[4:0], OP_STORE};
      CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], OP_BRANCH};
      CLS_LUI:    word = {imm[31:12], rd, OP_LUI};
      CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default:    bad_class = 1'b1;
    endcase
`ifdef ENCODER_RANGE_CHECK_EN
    imm_bad = cls == CLS_I_ALU ? (shift ? imm > 32'd63 : !i12)
            : (cls == CLS_LOAD || cls == CLS_STORE) ? !i12
            : cls == CLS_BRANCH ? (s < -4096 || s > 4094 || imm[0])
            : cls == CLS_JAL ? (s < -1048576 || s > 1048574 || imm[0])
            : cls == CLS_LUI ? |imm[11:0]
            : 1'b0;
`endif
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: streams field bundles, encodes RV64I words and writes them into IMEM.
// Optional immediate range checking via ENCODER_RANGE_CHECK_EN.
module instr_encoder_loader
  import rv_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  in_class,
  input  logic [2:0]  in_func3,
  input  logic [6:0]  in_func7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] count
);
  localparam logic [63:0] ADDR_LIMIT = BASE_ADDR + 64'(IMEM_DEPTH) * 64'd4;
  state_e state, nxt;
  err_code_e ecode;
  logic [63:0] addr;
  logic [31:0] word;
  logic bad_class, imm_bad, accept, restart;
  instr_field_packer u_packer (
    .cls(in_class), .func3(in_func3), .func7(in_func7), .rd(in_rd), .rs1(in_rs1),
    .rs2(in_rs2), .imm(in_imm), .word(word), .bad_class(bad_class), .imm_bad(imm_bad)
  );
  assign in_ready = state == LOAD;
  assign busy = state == LOAD || state == DONE;
  assign accept = in_valid && in_ready;
  assign restart = start && (state == IDLE || state == ERROR);
  assign ecode = bad_class ? ERR_BAD_CLASS : imm_bad ? ERR_IMM_RANGE
               : addr >= ADDR_LIMIT ? ERR_OVERFLOW : ERR_NONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = restart ? LOAD
        : state == LOAD ? (!accept ? LOAD : ecode != ERR_NONE ? ERROR : in_last ? DONE : LOAD)
        : state == DONE ? IDLE
        : state;
  end
  // the write port is registered: a legal accept shows up on imem_* one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= BASE_ADDR;
      count <= '0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= '0;
    end else begin
      imem_we <= accept && ecode == ERR_NONE;
      done <= state == DONE;
      if (restart) begin
        addr <= BASE_ADDR;
        count <= '0;
        err <= 1'b0;
        err_code <= '0;
      end else if (accept && ecode != ERR_NONE) begin
        err <= 1'b1;
        err_code <= ecode;
      end else if (accept) begin
        imem_addr <= addr;
        imem_wdata <= word;
        addr <= addr + 64'd4;
        count <= count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed plus randomized checks of the encoder/loader against a shift-and-mask model.
module tb_instr_encoder_loader;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [2:0] in_class = '0, in_func3 = '0;
  logic [6:0] in_func7 = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic in_ready, imem_we, busy, done, err;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0] err_code;
  logic [15:0] count;
  int checks = 0, failures = 0;
  logic [63:0] cap_a[$];
  logic [31:0] cap_d[$];
  logic [31:0] exp_d[$];

  instr_encoder_loader #(.BASE_ADDR(64'h0), .IMEM_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_class(in_class), .in_func3(in_func3), .in_func7(in_func7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (imem_we) begin
      cap_a.push_back(imem_addr);
      cap_d.push_back(imem_wdata);
    end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] enc(int c, int f3, int f7, int rd, int rs1, int rs2, int imm);
    int b, r;
    b = (rd << 7) | (f3 << 12) | (rs1 << 15);
    case (c)
      0: r = (f7 << 25) | (rs2 << 20) | b | 'h33;
      1: r = ((f3 & 3) == 1) ? (((f7 >> 1) << 26) | ((imm & 63) << 20) | b | 'h13)
                             : (((imm & 'hfff) << 20) | b | 'h13);
      2: r = ((imm & 'hfff) << 20) | b | 'h03;
      3: r = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm & 31) << 7) | 'h23;
      4: r = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
           | (f3 << 12) | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
      5: r = (imm & 'hfffff000) | (rd << 7) | 'h37;
      6: r = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
           | (((imm >> 12) & 255) << 12) | (rd << 7) | 'h6f;
      default: r = 0;
    endcase
    return 32'(r);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task automatic send(input int c, input int f3, input int f7, input int rd, input int rs1,
                      input int rs2, input int imm, input bit last);
    int t = 0;
    in_class = 3'(c); in_func3 = 3'(f3); in_func7 = 7'(f7);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 32'(imm);
    in_valid = 1'b1; in_last = last;
    while (!in_ready && t < 50) begin step; t++; end
    chk("ready_wait", 64'(in_ready), 64'd1);
    step;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic rand_bundle(output int c, output int f3, output int f7, output int rd,
                             output int rs1, output int rs2, output int imm);
    c = int'($urandom_range(0, 6)); f3 = int'($urandom_range(0, 7)); f7 = int'($urandom_range(0, 127));
    rd = int'($urandom_range(0, 31)); rs1 = int'($urandom_range(0, 31)); rs2 = int'($urandom_range(0, 31));
    case (c)
      1: imm = ((f3 & 3) == 1) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 4095)) - 2048;
      2, 3: imm = int'($urandom_range(0, 4095)) - 2048;
      4: imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
      5: imm = int'($urandom & 32'hfffff000);
      6: imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      default: imm = int'($urandom);
    endcase
  endtask

  initial begin
    int c, f3, f7, rd, rs1, rs2, imm, n;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_we", 64'(imem_we), 0);
    chk("rst_ready", 64'(in_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_misc", {imem_addr[31:0], imem_wdata}, 0);
    chk("rst_flags", {45'd0, done, err, err_code, count}, 0);
    step;
    rst_n = 1'b1;
    step;
    chk("idle_ready", 64'(in_ready), 0);

    // R-type, single-word program
    pulse_start;
    chk("load_busy", 64'(busy), 1);
    send(0, 0, 0, 1, 2, 3, 0, 1'b1);
    chk("r_we", 64'(imem_we), 1);
    chk("r_addr", imem_addr, 64'h0);
    chk("r_wdata", 64'(imem_wdata), 64'h003100B3);
    chk("r_count", 64'(count), 1);
    chk("r_done_early", 64'(done), 0);
    step;
    chk("r_done", 64'(done), 1);
    chk("r_we_off", 64'(imem_we), 0);
    step;
    chk("r_done_once", 64'(done), 0);
    chk("r_idle_busy", 64'(busy), 0);

    // addi / ld
    pulse_start;
    send(1, 0, 0, 5, 0, 0, -1, 1'b0);
    chk("addi_w", {imem_addr[31:0], imem_wdata}, {32'h0, 32'hFFF00293});
    send(2, 3, 0, 6, 5, 0, 8, 1'b0);
    chk("ld_w", {imem_addr[31:0], imem_wdata}, {32'h4, 32'h0082B303});
    // a start mid-session must not restart the counters
    pulse_start;
    chk("start_ignored", 64'(count), 2);
    send(3, 3, 0, 0, 5, 6, -4, 1'b0);
    chk("sd_w", {imem_addr[31:0], imem_wdata}, {32'h8, 32'hFE62BE23});
    send(4, 0, 0, 0, 1, 2, -8, 1'b1);
    chk("beq_w", {imem_addr[31:0], imem_wdata}, {32'hC, 32'hFE208CE3});
    step;
    chk("beq_done", 64'(done), 1);
    chk("beq_count", 64'(count), 4);

    // reserved class
    pulse_start;
    send(7, 0, 0, 1, 1, 1, 0, 1'b1);
    chk("bad_we", 64'(imem_we), 0);
    chk("bad_err", {err, err_code, in_ready}, {1'b1, 2'd1, 1'b0});
    in_valid = 1'b1;
    step; step;
    chk("bad_ignored", {imem_we, done, busy}, 3'b000);
    in_valid = 1'b0;
    pulse_start;
    chk("bad_clear", {err, err_code, in_ready}, {1'b0, 2'd0, 1'b1});

    // out-of-range immediate
    send(1, 0, 0, 1, 1, 0, 2048, 1'b1);
`ifdef ENCODER_RANGE_CHECK_EN
    chk("range_err", {imem_we, err, err_code, in_ready}, {1'b0, 1'b1, 2'd2, 1'b0});
    pulse_start;
    chk("range_clear", {err, in_ready}, 2'b01);
    send(0, 0, 0, 0, 0, 0, 0, 1'b1);
`else
    chk("trunc_w", {imem_we, err, imem_wdata}, {1'b1, 1'b0, enc(1, 0, 0, 1, 1, 0, 2048)});
`endif
    step; step;

    // overflow: 8-word IMEM
    pulse_start;
    cap_a.delete(); cap_d.delete();
    for (int i = 0; i < 8; i++) send(0, 0, 0, i, i, i, 0, 1'b0);
    send(0, 0, 0, 9, 9, 9, 0, 1'b1);
    chk("ovf_err", {imem_we, err, err_code, in_ready}, {1'b0, 1'b1, 2'd3, 1'b0});
    chk("ovf_count", 64'(count), 8);
    step; step;
    chk("ovf_nodone", 64'(done), 0);
    chk("ovf_writes", 64'(cap_a.size()), 8);
    chk("ovf_last_addr", cap_a[cap_a.size() - 1], 64'h1C);

    // randomized sessions against the model
    for (int s = 0; s < 6; s++) begin
      pulse_start;
      cap_a.delete(); cap_d.delete(); exp_d.delete();
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        rand_bundle(c, f3, f7, rd, rs1, rs2, imm);
        exp_d.push_back(enc(c, f3, f7, rd, rs1, rs2, imm));
        repeat ($urandom_range(0, 2)) step;
        send(c, f3, f7, rd, rs1, rs2, imm, i == n - 1);
      end
      step;
      chk("rnd_done", {done, err, count}, {1'b1, 1'b0, 16'(n)});
      chk("rnd_nwrites", 64'(cap_d.size()), 64'(n));
      for (int i = 0; i < n && i < cap_d.size(); i++) begin
        chk("rnd_addr", cap_a[i], 64'(4 * i));
        chk("rnd_word", 64'(cap_d[i]), 64'(exp_d[i]));
      end
    end

    // reset during a session with a write pending
    pulse_start;
    send(0, 0, 0, 1, 2, 3, 0, 1'b0);
    in_valid = 1'b1;
    chk("pre_rst_we", 64'(imem_we), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {imem_we, in_ready, busy, done, err, err_code, count}, 23'd0);
    rst_n = 1'b1;
    step; step; step;
    chk("post_rst", {imem_we, in_ready, busy}, 3'b000);
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart to the control_unit decoder: takes instruction fields (class, func3, func7, rd, rs1, rs2, imm) over a valid/ready stream.
- Assembles legal RV64I 32-bit instruction words and writes them sequentially into instruction memory through a registered write port.
- Used by bring-up and self-test benches to load programs into the single-cycle core's IMEM before release from reset.

Parameters:
- BASE_ADDR, 64'h0, byte address of the first instruction written.
- IMEM_DEPTH, 256, instruction words available; the write address must stay below BASE_ADDR + 4*IMEM_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a load session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_last  in  1  bundle is the final instruction of the program.
- in_class  in  3  0=R, 1=I_ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5=LUI, 6=JAL, 7=reserved.
- in_func3  in  3  func3 field.
- in_func7  in  7  func7 field (R type; bits [6:1] reused as imm[11:6] for I_ALU shifts).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate.
- imem_we  out  1  write strobe.
- imem_addr  out  64  byte address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  session active.
- done  out  1  one-cycle pulse after the last word is written.
- err  out  1  sticky error flag.
- err_code  out  2  0=none, 1=bad class, 2=imm out of range, 3=IMEM overflow.
- count  out  16  words written in the current session.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; address register = BASE_ADDR.
- FSM states and transitions:
  - IDLE: start -> LOAD; clears count and err, address = BASE_ADDR.
  - LOAD: in_ready = 1.
    - On in_valid & in_ready with a legal encoding: register the word and address. imem_we is asserted the next cycle (latency 1). Then count += 1 and address += 4.
    - If in_last was set on the accepted bundle: -> DONE.
  - DONE: done = 1 for exactly one cycle, imem_we = 0 -> IDLE.
  - ERROR: in_ready = 0, imem_we never asserted; only start exits, -> LOAD with err cleared.
- busy = 1 in LOAD and DONE.
- in_ready = 0 in IDLE, DONE and ERROR. Bundles offered there are ignored.
- Encodings (bit fields as RISC-V spec):
  - R: func7|rs2|rs1|func3|rd|0110011.
  - I_ALU: imm[11:0]|rs1|func3|rd|0010011. For func3 001/101, bits [31:26] = func7[6:1] and [25:20] = imm[5:0] (6-bit shamt).
  - LOAD: imm[11:0]|rs1|func3|rd|0000011.
  - STORE: imm[11:5]|rs2|rs1|func3|imm[4:0]|0100011.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|func3|imm[4:1]|imm[11]|1100011.
  - LUI: imm[31:12]|rd|0110111.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
- Error rules:
  - Class 7 -> err_code 1; word not written; -> ERROR.
  - Accepted bundle whose address would reach BASE_ADDR + 4*IMEM_DEPTH -> err_code 3, no write, -> ERROR. A write to the last legal word succeeds.
  - Error on the in_last bundle: ERROR takes priority and no done pulse is generated.
- Simultaneous events: start while in LOAD is ignored.
- Reset mid-session: returns to IDLE immediately. Any pending write is dropped (imem_we deasserts asynchronously).

Optional Feature:
- Macro ENCODER_RANGE_CHECK_EN.
- Defined: immediates are checked; violations give err_code 2 and -> ERROR. Legal ranges:
  - I/LOAD/STORE: -2048..2047.
  - I_ALU shift: 0..63.
  - BRANCH: -4096..4094 and even.
  - JAL: -1048576..1048574 and even.
  - LUI: imm[11:0] == 0.
- Undefined: immediates are silently truncated to the field bits; err_code 2 is never produced.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL);
  - the instr_class_e enum;
  - the err_code_e enum.
- One combinational sub-module, instr_field_packer: maps the class plus fields to {word, bad_class, imm_bad}.
- The FSM, address/count registers and write port live in the top module.

Test Plan:
- start; R bundle func7=0, rs2=3, rs1=2, func3=0, rd=1, in_last=1 -> next cycle imem_we=1, addr=0x0, wdata=0x003100B3, then done pulse, count=1.
- I_ALU addi rd=5, rs1=0, imm=-1, then LOAD ld rd=6, rs1=5, func3=011, imm=8 -> words 0xFFF00293, 0x0082B303 at addrs 0x0, 0x4.
- STORE sd rs2=6, rs1=5, imm=-4, func3=011, then BRANCH beq rs1=1, rs2=2, imm=-8 -> 0xFE62BE23, 0xFE208CE3.
- With ENCODER_RANGE_CHECK_EN: I_ALU imm=2048 -> no imem_we, err=1, err_code=2, in_ready=0; a later start clears err and restores in_ready.
- IMEM_DEPTH=2: three bundles -> two writes (0x0, 0x4), third gives err_code=3, count=2.
- Assert rst_n low while in_valid is high mid-session -> all outputs 0 immediately; after release busy=0 until start.
